// File: rtl/touch_pkg.sv
// Shared definitions for the ADS7843-style touch ADC responder: channel codes,
// FSM states, framing constants and a saturating counter helper.
package touch_pkg;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    WAIT_BUSY,
    CONV,
    DATA
  } touch_state_e;

  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned DATA_FRAME = 16;
  localparam int unsigned CNT_W      = 5;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/touch_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with single-cycle rise/fall
// pulses derived from a delayed copy of the synchronized value.
module touch_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/touch_adc_responder.sv
// Device end of the touch SPI link: captures the control byte, raises busy for
// one clock, then shifts out a 12- or 8-bit result over a 16-fall data phase.
module touch_adc_responder
  import touch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_BITS   = 12
) (
  input  logic                 cclk,
  input  logic                 rstb,
  input  logic                 touch_clk,
  input  logic                 touch_csb,
  input  logic                 touch_data_in,
  output logic                 touch_data_out,
  output logic                 touch_busy,
  input  logic                 pen_down,
  input  logic [DATA_BITS-1:0] x_val,
  input  logic [DATA_BITS-1:0] y_val,
  input  logic [DATA_BITS-1:0] z_val,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_byte
);

  localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(DATA_FRAME);
  localparam logic [CNT_W-1:0] BITS_8    = CNT_W'(8);
  localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(DATA_BITS);

  logic clk_s, clk_rise, clk_fall;
  logic csb_s, csb_rise, csb_fall;
  logic din_s;
  logic unused_sync;

  touch_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk_i  (cclk),
    .rst_ni (rstb),
    .d_i    (touch_clk),
    .q_o    (clk_s),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );

  touch_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
    .clk_i  (cclk),
    .rst_ni (rstb),
    .d_i    (touch_csb),
    .q_o    (csb_s),
    .rise_o (csb_rise),
    .fall_o (csb_fall)
  );

  assign unused_sync = ^{clk_s, csb_rise, csb_fall};

  // Data input gets the same depth as touch_clk so it stays aligned to the rise pulse.
  logic [SYNC_STAGES-1:0] din_sync_q;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) din_sync_q <= '0;
    else       din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], touch_data_in};
  end

  assign din_s = din_sync_q[SYNC_STAGES-1];

  touch_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       nbits_q, nbits_d;
  logic [CNT_W-1:0]       fall_cnt_q, fall_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             cmd_byte_q, cmd_byte_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [DATA_BITS-1:0]   sample_q, sample_d;
  logic [DATA_BITS-1:0]   data_sr_q, data_sr_d;
  logic                   dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic [DATA_BITS-1:0]   sel_sample;
  logic [CNT_W-1:0]       bit_limit;

  always_comb begin
    sel_sample = '0;
    if (pen_down) begin
      case (cmd_byte_q[6:4])
        CH_X:    sel_sample = x_val;
        CH_Y:    sel_sample = y_val;
        CH_Z1:   sel_sample = z_val;
        default: sel_sample = '0;
      endcase
    end
  end

  assign bit_limit = cmd_byte_q[3] ? BITS_8 : BITS_FULL;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      nbits_q     <= '0;
      fall_cnt_q  <= '0;
      shreg_q     <= '0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      sample_q    <= '0;
      data_sr_q   <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbits_q     <= nbits_d;
      fall_cnt_q  <= fall_cnt_d;
      shreg_q     <= shreg_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      sample_q    <= sample_d;
      data_sr_q   <= data_sr_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbits_d     = nbits_q;
    fall_cnt_d  = fall_cnt_q;
    shreg_d     = shreg_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    sample_d    = sample_q;
    data_sr_d   = data_sr_q;
    dout_d      = dout_q;
    busy_d      = busy_q;

    if (csb_s) begin
      state_d    = HUNT;
      cnt_d      = '0;
      nbits_d    = '0;
      fall_cnt_d = '0;
      dout_d     = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (clk_rise && din_s) begin
            shreg_d = 8'h01;
            cnt_d   = CNT_W'(1);
            state_d = CMD;
          end
        end
        CMD: begin
          if (clk_rise) begin
            shreg_d = {shreg_q[6:0], din_s};
            cnt_d   = sat_inc(cnt_q);
            if (cnt_d == CMD_END) begin
              cmd_byte_d  = shreg_d;
              cmd_valid_d = 1'b1;
              state_d     = WAIT_BUSY;
            end
          end
        end
        WAIT_BUSY: begin
          if (clk_fall) begin
            busy_d   = 1'b1;
            sample_d = sel_sample;
            state_d  = CONV;
          end
        end
        CONV: begin
          if (clk_fall) begin
            busy_d     = 1'b0;
            dout_d     = sample_q[DATA_BITS-1];
            data_sr_d  = sample_q << 1;
            nbits_d    = CNT_W'(1);
            fall_cnt_d = CNT_W'(1);
            state_d    = DATA;
          end
        end
        DATA: begin
          // The CONV fall is fall 1 of the frame; fall 16 ends it and re-arms start hunting.
          if (clk_fall) begin
            fall_cnt_d = sat_inc(fall_cnt_q);
            data_sr_d  = data_sr_q << 1;
            if (fall_cnt_d == FRAME_END) begin
              dout_d  = 1'b0;
              cnt_d   = '0;
              state_d = HUNT;
            end else if (nbits_q < bit_limit) begin
              dout_d  = data_sr_q[DATA_BITS-1];
              nbits_d = sat_inc(nbits_q);
            end else begin
              dout_d = 1'b0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign touch_data_out = dout_q;
  assign touch_busy     = busy_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_byte       = cmd_byte_q;

endmodule

// File: tb/tb_touch_adc_responder.sv
// Directed bench acting as the SPI master for touch_adc_responder.
module tb_touch_adc_responder;

  localparam int HALF = 80;

  logic        cclk = 1'b0;
  logic        rstb;
  logic        touch_clk;
  logic        touch_csb;
  logic        touch_data_in;
  logic        touch_data_out;
  logic        touch_busy;
  logic        pen_down;
  logic [11:0] x_val, y_val, z_val;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;

  always #5 cclk = ~cclk;

  always @(negedge cclk) if (cmd_valid) valid_cnt++;

  touch_adc_responder #(.SYNC_STAGES(2), .DATA_BITS(12)) dut (
    .cclk           (cclk),
    .rstb           (rstb),
    .touch_clk      (touch_clk),
    .touch_csb      (touch_csb),
    .touch_data_in  (touch_data_in),
    .touch_data_out (touch_data_out),
    .touch_busy     (touch_busy),
    .pen_down       (pen_down),
    .x_val          (x_val),
    .y_val          (y_val),
    .z_val          (z_val),
    .cmd_valid      (cmd_valid),
    .cmd_byte       (cmd_byte)
  );

  // One touch_clk period; outputs sampled just before the rise, as the master does.
  task automatic clock_bit(input logic din, output logic dout_s, output logic busy_s);
    touch_data_in = din;
    #HALF;
    dout_s = touch_data_out;
    busy_s = touch_busy;
    touch_clk = 1'b1;
    #HALF;
    touch_clk = 1'b0;
  endtask

  // 24-clock frame; data[15] is the bit driven on fall 9, busy_tr[k] precedes rise k+1.
  task automatic run_txn(input logic [7:0] cmd, input logic corrupt,
                         output logic [15:0] data, output logic [24:0] busy_tr);
    logic d, b;
    data = '0;
    busy_tr = '0;
    for (int k = 0; k < 24; k++) begin
      clock_bit((k < 8) ? cmd[7-k] : 1'b0, d, b);
      busy_tr[k] = b;
      if (k >= 9) data[15-(k-9)] = d;
      if (corrupt && k == 12) begin
        x_val = ~x_val;
        y_val = ~y_val;
        z_val = ~z_val;
        pen_down = 1'b0;
      end
    end
    #HALF;
    busy_tr[24] = touch_busy;
    data[0] = touch_data_out;
  endtask

  task automatic test_reset;
    checks += 4;
    if (touch_data_out !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", touch_data_out); end
    if (touch_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", touch_busy); end
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    if (cmd_byte !== 8'h00) begin failures++; $display("FAIL reset_cmd_byte got=%h exp=00", cmd_byte); end
  endtask

  task automatic test_read_y;
    logic [15:0] data; logic [24:0] bt; int v0;
    pen_down = 1'b1; y_val = 12'hA5C;
    v0 = valid_cnt;
    run_txn(8'h90, 1'b0, data, bt);
    checks += 4;
    if (data !== 16'hA5C0) begin failures++; $display("FAIL y_data got=%h exp=a5c0", data); end
    if (bt !== 25'h100) begin failures++; $display("FAIL y_busy got=%h exp=0000100", bt); end
    if (cmd_byte !== 8'h90) begin failures++; $display("FAIL y_cmd_byte got=%h exp=90", cmd_byte); end
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL y_valid_pulses got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_read_x_8bit;
    logic [15:0] data; logic [24:0] bt;
    pen_down = 1'b1; x_val = 12'h3C7;
    run_txn(8'hD8, 1'b0, data, bt);
    checks += 3;
    if (data !== 16'h3C00) begin failures++; $display("FAIL x8_data got=%h exp=3c00", data); end
    if (bt !== 25'h100) begin failures++; $display("FAIL x8_busy got=%h exp=0000100", bt); end
    if (cmd_byte !== 8'hD8) begin failures++; $display("FAIL x8_cmd_byte got=%h exp=d8", cmd_byte); end
  endtask

  task automatic test_pen_up;
    logic [15:0] data; logic [24:0] bt;
    pen_down = 1'b0; z_val = 12'hFFF;
    run_txn(8'hB0, 1'b0, data, bt);
    checks += 2;
    if (data !== 16'h0000) begin failures++; $display("FAIL penup_data got=%h exp=0000", data); end
    if (bt !== 25'h100) begin failures++; $display("FAIL penup_busy got=%h exp=0000100", bt); end
  endtask

  task automatic test_leading_zeros;
    logic [15:0] data; logic [24:0] bt; logic d, b; int v0;
    pen_down = 1'b1; y_val = 12'hA5C;
    v0 = valid_cnt;
    clock_bit(1'b0, d, b);
    clock_bit(1'b0, d, b);
    run_txn(8'h90, 1'b0, data, bt);
    checks += 3;
    if (data !== 16'hA5C0) begin failures++; $display("FAIL lz_data got=%h exp=a5c0", data); end
    if (bt !== 25'h100) begin failures++; $display("FAIL lz_busy got=%h exp=0000100", bt); end
    if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL lz_valid_pulses got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_csb_abort;
    logic [15:0] data; logic [24:0] bt; logic [7:0] cmd; logic d, b;
    pen_down = 1'b1; x_val = 12'h1FF; cmd = 8'hD0;
    for (int k = 0; k < 12; k++) clock_bit((k < 8) ? cmd[7-k] : 1'b0, d, b);
    #HALF;
    checks += 1;
    if (touch_data_out !== 1'b1) begin failures++; $display("FAIL abort_pre_dout got=%b exp=1", touch_data_out); end
    touch_csb = 1'b1;
    #31;
    checks += 2;
    if (touch_data_out !== 1'b0) begin failures++; $display("FAIL abort_dout got=%b exp=0", touch_data_out); end
    if (touch_busy !== 1'b0) begin failures++; $display("FAIL abort_busy0 got=%b exp=0", touch_busy); end
    #HALF;
    touch_csb = 1'b0;
    for (int k = 0; k < 8; k++) clock_bit(cmd[7-k], d, b);
    #HALF;
    checks += 1;
    if (touch_busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", touch_busy); end
    touch_csb = 1'b1;
    #31;
    checks += 1;
    if (touch_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", touch_busy); end
    #HALF;
    touch_csb = 1'b0;
    run_txn(cmd, 1'b0, data, bt);
    checks += 2;
    if (data !== 16'h1FF0) begin failures++; $display("FAIL abort_after_data got=%h exp=1ff0", data); end
    if (bt !== 25'h100) begin failures++; $display("FAIL abort_after_busy got=%h exp=0000100", bt); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] data; logic [24:0] bt; logic [7:0] cmd; logic d, b;
    pen_down = 1'b1; y_val = 12'hABC; cmd = 8'h90;
    for (int k = 0; k < 12; k++) clock_bit((k < 8) ? cmd[7-k] : 1'b0, d, b);
    #HALF;
    rstb = 1'b0;
    #1;
    checks += 3;
    if (touch_data_out !== 1'b0) begin failures++; $display("FAIL rstmid_dout got=%b exp=0", touch_data_out); end
    if (touch_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", touch_busy); end
    if (cmd_byte !== 8'h00) begin failures++; $display("FAIL rstmid_cmd_byte got=%h exp=00", cmd_byte); end
    #19;
    rstb = 1'b1;
    #HALF;
    y_val = 12'h5A3;
    run_txn(cmd, 1'b1, data, bt);
    checks += 3;
    if (data !== 16'h5A30) begin failures++; $display("FAIL rstmid_data got=%h exp=5a30", data); end
    if (bt !== 25'h100) begin failures++; $display("FAIL rstmid_busy_tr got=%h exp=0000100", bt); end
    if (cmd_byte !== 8'h90) begin failures++; $display("FAIL rstmid_cmd got=%h exp=90", cmd_byte); end
  endtask

  initial begin
    rstb = 1'b0;
    touch_clk = 1'b0;
    touch_csb = 1'b1;
    touch_data_in = 1'b0;
    pen_down = 1'b0;
    x_val = '0; y_val = '0; z_val = '0;
    #50;
    test_reset;
    rstb = 1'b1;
    #40;
    touch_csb = 1'b0;
    #HALF;
    test_read_y;
    test_read_x_8bit;
    test_pen_up;
    test_leading_zeros;
    test_csb_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/touch_adc_responder.md
Name: touch_adc_responder

Overview:
- Synthesizable emulator of the ADS7843-style serial touch ADC, i.e. the device end of the touch SPI link that touchpad_controller drives.
- It receives touch_clk, touch_csb and the command bit stream, and returns touch_busy plus 12-bit conversion results taken from programmable x/y/z inputs (switches, buttons or a bench).
- It lets touchpad_controller and the screen-coordinate path be exercised on the board and in simulation without the physical panel.

Parameters:
- SYNC_STAGES, 2, number of cclk flops synchronizing touch_clk, touch_csb and touch_data_in (minimum 2).
- DATA_BITS, 12, full-resolution result width.

Ports:
- cclk, input, 1, system clock (100 MHz). Single clock domain.
- rstb, input, 1, asynchronous active-low reset.
- touch_clk, input, 1, serial clock from the master (asynchronous to cclk).
- touch_csb, input, 1, active-low chip select from the master.
- touch_data_in, input, 1, command bits from the master (master data_out).
- touch_data_out, output, 1, result bits to the master (master data_in).
- touch_busy, output, 1, conversion-busy flag.
- pen_down, input, 1, 1 = emulated touch present.
- x_val, input, 12, emulated X result.
- y_val, input, 12, emulated Y result.
- z_val, input, 12, emulated Z1 pressure result.
- cmd_valid, output, 1, one-cclk pulse when a full control byte has been captured.
- cmd_byte, output, 8, last captured control byte.

Behaviour:
- Reset (rstb=0, async): state HUNT; touch_data_out=0; touch_busy=0; cmd_valid=0; cmd_byte=8'h00; bit counter=0; synchronizer flops=0, except the touch_csb chain, which resets to 1.
- Edges: rise and fall of the synchronized touch_clk are detected with a delayed copy. All outputs update on the cclk after detection, so latency from a pin edge to an output change is SYNC_STAGES+1 cclk.
- Master requirement: touch_clk high and low times are each >= SYNC_STAGES+2 cclk.
- touch_data_in is sampled on the touch_clk rise. Outputs change only on the touch_clk fall.
- Synchronized touch_csb=1, at any time including mid-operation: go to HUNT, clear the counter, drive touch_data_out=0 and touch_busy=0 on the next cclk. Edges are ignored while csb=1.
- HUNT: on a rise with din=1 (start bit), load shreg=1, cnt=1 and go to CMD. Rises with din=0 are ignored, so leading zeros are allowed.
- CMD: on each rise, shift din in MSB-first and increment cnt. When cnt reaches 8:
  - cmd_byte <= shreg and cmd_valid pulses for 1 cclk.
  - Channel field is A[2:0] = cmd_byte[6:4].
  - Mode bit M = cmd_byte[3]: 1 = 8-bit result, 0 = 12-bit result.
  - Go to WAIT_BUSY.
- WAIT_BUSY: on the next fall, touch_busy=1 and the sample is latched (hold value fixed from here on). Go to CONV.
- Sample selection:
  - pen_down=0: sample = 0.
  - A=101: sample = x_val.
  - A=001: sample = y_val.
  - A=011: sample = z_val.
  - Any other A: sample = 12'h000.
- CONV: on the next fall, touch_busy=0, touch_data_out = sample[11], nbits=1, go to DATA.
- DATA:
  - On each fall, output the next bit MSB-first while nbits < (M ? 8 : 12). After that, drive 0.
  - Total data phase: 16 falls counted from the CONV fall.
  - After the 16th fall, return to HUNT with touch_data_out=0.
- DATA overlap: rises in DATA with din=1 are not starts. A new command is recognised only in HUNT. With the 24-clock framing this gives contiguous transactions, and csb may stay low between them.
- Simultaneous events:
  - csb rise in the same cclk as a touch_clk edge: csb wins.
  - pen_down or x/y/z changing after the sample latch do not affect the current transfer.
- Widths: values passed through unmodified, with no arithmetic and no wrap-around. The bit counters are 5 bits and saturate at their terminal values.

Decomposition:
- Shared package, touch_pkg: the channel codes (CH_X=3'b101, CH_Y=3'b001, CH_Z1=3'b011), the state encodings (HUNT, CMD, WAIT_BUSY, CONV, DATA), CMD_BITS=8 and DATA_FRAME=16.
- One natural sub-module, touch_sync_edge: an N-stage synchronizer with rise/fall pulse outputs. It is instantiated for touch_clk and for touch_csb. touch_data_in uses plain sync stages.

Test Plan:
- Reset, then csb=0, clock byte 8'h90 (start, A=001, 12-bit) with y_val=12'hA5C and pen_down=1 -> cmd_valid pulse, cmd_byte=8'h90. touch_busy high for exactly one touch_clk period after falling edge 8. touch_data_out bits then read 1010_0101_1100_0000 (16 falls). The master touchpad_controller reports y=12'hA5C.
- Byte 8'hD8 (A=101, 8-bit) with x_val=12'h3C7 -> data bits 0011_1100 followed by eight 0s.
- pen_down=0, byte 8'hB0 (Z1) with z_val=12'hFFF -> 16 zero data bits. touch_busy still pulses once.
- Two leading zeros, then 8'h90 -> same response as scenario 1, proving start-bit hunting.
- csb raised after falling edge 12 -> within SYNC_STAGES+1 cclk, touch_data_out=0, touch_busy=0, state HUNT. A fresh 8'hD0 afterwards returns x_val correctly.
- rstb pulsed low mid-DATA -> all outputs go to their reset values asynchronously. The next full transaction is correct, and value changes after the sample latch are not reflected.
